// File: rtl/fp_mul_seq_if.sv
// Handshake bundle for fp_mul_seq: operand/rounding-mode request and result/flags response.
interface fp_mul_seq_if #(
  parameter int unsigned EXP_W = 8,
  parameter int unsigned MAN_W = 23
);
  localparam int unsigned W = 1 + EXP_W + MAN_W;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_numA;
  logic [W-1:0] in_numB;
  logic [2:0]   rm;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_result;
  logic [4:0]   fflags;

  modport master (
    output in_valid, in_numA, in_numB, rm, out_ready,
    input  in_ready, out_valid, out_result, fflags
  );

  modport slave (
    input  in_valid, in_numA, in_numB, rm, out_ready,
    output in_ready, out_valid, out_result, fflags
  );
endinterface

// File: rtl/fp_mul_seq.sv
// Sequential IEEE-754 multiplier: shift-add significand product, one multiplier bit per cycle.
// Special operands (zero, subnormal, inf, NaN, illegal rm) bypass straight to DONE.
module fp_mul_seq #(
  parameter int unsigned EXP_W = 8,
  parameter int unsigned MAN_W = 23
) (
  input logic         clk,
  input logic         rst,
  fp_mul_seq_if.slave bus
);
  localparam int unsigned W     = 1 + EXP_W + MAN_W;
  localparam int unsigned SigW  = MAN_W + 1;
  localparam int unsigned ExpIW = EXP_W + 2;
  localparam int unsigned CntW  = $clog2(SigW);

  localparam logic [CntW-1:0]         CntLast   = CntW'(SigW - 1);
  localparam logic signed [ExpIW-1:0] Bias      = ExpIW'((1 << (EXP_W - 1)) - 1);
  localparam logic signed [ExpIW-1:0] ExpSat    = ExpIW'((1 << EXP_W) - 1);
  localparam logic signed [ExpIW-1:0] ExpOne    = ExpIW'(1);
  localparam logic signed [ExpIW-1:0] ExpZero   = '0;
  localparam logic [EXP_W-1:0]        ExpOnes   = {EXP_W{1'b1}};
  localparam logic [EXP_W-1:0]        ExpMaxFin = {{(EXP_W - 1){1'b1}}, 1'b0};

  typedef enum logic [2:0] {StIdle, StMul, StNorm, StRnd, StDone} state_e;
  state_e state_q, state_d;

  logic                    sign_q, sign_d;
  logic [2:0]              rm_q, rm_d;
  logic signed [ExpIW-1:0] exp_q, exp_d;
  logic [SigW-1:0]         mcand_q, mcand_d;
  logic [2*SigW-1:0]       prod_q, prod_d;
  logic [CntW-1:0]         cnt_q, cnt_d;
  logic [SigW-1:0]         man_q, man_d;
  logic                    grd_q, grd_d, stk_q, stk_d;
  logic [W-1:0]            result_q, result_d;
  logic [4:0]              flags_q, flags_d;

  // Operand classification
  logic             sign_a, sign_b;
  logic [EXP_W-1:0] exp_a, exp_b;
  logic [MAN_W-1:0] man_a, man_b;
  logic             zero_a, zero_b, inf_a, inf_b, nan_a, nan_b, snan_a, snan_b;
  logic             bad_rm, inv_op, nan_res, special;
  logic [W-1:0]     spec_res;
  logic [4:0]       spec_flags;

  assign {sign_a, exp_a, man_a} = bus.in_numA;
  assign {sign_b, exp_b, man_b} = bus.in_numB;

  assign zero_a  = (exp_a == '0);
  assign zero_b  = (exp_b == '0);
  assign inf_a   = (exp_a == ExpOnes) & (man_a == '0);
  assign inf_b   = (exp_b == ExpOnes) & (man_b == '0);
  assign nan_a   = (exp_a == ExpOnes) & (man_a != '0);
  assign nan_b   = (exp_b == ExpOnes) & (man_b != '0);
  assign snan_a  = nan_a & ~man_a[MAN_W-1];
  assign snan_b  = nan_b & ~man_b[MAN_W-1];
  assign bad_rm  = (bus.rm > 3'd4);
  assign inv_op  = (inf_a & zero_b) | (zero_a & inf_b);
  assign nan_res = bad_rm | nan_a | nan_b | inv_op;
  assign special = nan_res | inf_a | inf_b | zero_a | zero_b;

  always_comb begin
    spec_res   = '0;
    spec_flags = '0;
    if (nan_res) begin
      spec_res      = {1'b0, ExpOnes, 1'b1, {(MAN_W - 1){1'b0}}};
      spec_flags[4] = bad_rm | snan_a | snan_b | inv_op;
    end else if (inf_a | inf_b) begin
      spec_res = {sign_a ^ sign_b, ExpOnes, {MAN_W{1'b0}}};
    end else begin
      spec_res = {sign_a ^ sign_b, {(W - 1){1'b0}}};
    end
  end

  // Right-shifting shift-add: multiplier lives in the low half of prod_q and is consumed LSB first
  logic [SigW:0] mul_sum;
  assign mul_sum = {1'b0, prod_q[2*SigW-1:SigW]} + (prod_q[0] ? {1'b0, mcand_q} : '0);

  // Rounding
  logic                    nx, rnd_inc, to_inf;
  logic [SigW:0]           man_r;
  logic [MAN_W-1:0]        frac_r;
  logic signed [ExpIW-1:0] exp_r;

  always_comb begin
    nx = grd_q | stk_q;
    case (rm_q)
      3'd0:    rnd_inc = grd_q & (stk_q | man_q[0]);
      3'd2:    rnd_inc = sign_q & nx;
      3'd3:    rnd_inc = ~sign_q & nx;
      3'd4:    rnd_inc = grd_q;
      default: rnd_inc = 1'b0;
    endcase
    man_r  = {1'b0, man_q} + {{SigW{1'b0}}, rnd_inc};
    frac_r = man_r[SigW] ? man_r[SigW-1:1] : man_r[SigW-2:0];
    exp_r  = man_r[SigW] ? exp_q + ExpOne : exp_q;
    to_inf = (rm_q == 3'd0) | (rm_q == 3'd4) | ((rm_q == 3'd3) & ~sign_q) |
             ((rm_q == 3'd2) & sign_q);
  end

  // FSM: state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (bus.in_valid) state_d = special ? StDone : StMul;
      StMul:   if (cnt_q == CntLast) state_d = StNorm;
      StNorm:  state_d = StRnd;
      StRnd:   state_d = StDone;
      StDone:  if (bus.out_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM: outputs
  always_comb begin
    bus.in_ready   = (state_q == StIdle);
    bus.out_valid  = (state_q == StDone);
    bus.out_result = result_q;
    bus.fflags     = flags_q;
  end

  // Datapath next state
  always_comb begin
    sign_d   = sign_q;
    rm_d     = rm_q;
    exp_d    = exp_q;
    mcand_d  = mcand_q;
    prod_d   = prod_q;
    cnt_d    = cnt_q;
    man_d    = man_q;
    grd_d    = grd_q;
    stk_d    = stk_q;
    result_d = result_q;
    flags_d  = flags_q;
    unique case (state_q)
      StIdle: begin
        if (bus.in_valid) begin
          sign_d  = sign_a ^ sign_b;
          rm_d    = bus.rm;
          exp_d   = $signed({2'b00, exp_a}) + $signed({2'b00, exp_b}) - Bias;
          mcand_d = {1'b1, man_a};
          prod_d  = {{SigW{1'b0}}, 1'b1, man_b};
          cnt_d   = '0;
          if (special) begin
            result_d = spec_res;
            flags_d  = spec_flags;
          end
        end
      end
      StMul: begin
        prod_d = {mul_sum, prod_q[SigW-1:1]};
        cnt_d  = cnt_q + 1'b1;
      end
      StNorm: begin
        if (prod_q[2*SigW-1]) begin
          man_d = prod_q[2*SigW-1:SigW];
          grd_d = prod_q[SigW-1];
          stk_d = |prod_q[SigW-2:0];
          exp_d = exp_q + ExpOne;
        end else begin
          man_d = prod_q[2*SigW-2:SigW-1];
          grd_d = prod_q[SigW-2];
          stk_d = |prod_q[SigW-3:0];
        end
      end
      StRnd: begin
        if (exp_r >= ExpSat) begin
          result_d = to_inf ? {sign_q, ExpOnes, {MAN_W{1'b0}}}
                            : {sign_q, ExpMaxFin, {MAN_W{1'b1}}};
          flags_d  = 5'b00101;
        end else if (exp_r <= ExpZero) begin
          // No subnormal outputs: flush to signed zero
          result_d = {sign_q, {(W - 1){1'b0}}};
          flags_d  = 5'b00011;
        end else begin
          result_d = {sign_q, exp_r[EXP_W-1:0], frac_r};
          flags_d  = {4'b0000, nx};
        end
      end
      StDone: ;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sign_q   <= 1'b0;
      rm_q     <= '0;
      exp_q    <= '0;
      mcand_q  <= '0;
      prod_q   <= '0;
      cnt_q    <= '0;
      man_q    <= '0;
      grd_q    <= 1'b0;
      stk_q    <= 1'b0;
      result_q <= '0;
      flags_q  <= '0;
    end else begin
      sign_q   <= sign_d;
      rm_q     <= rm_d;
      exp_q    <= exp_d;
      mcand_q  <= mcand_d;
      prod_q   <= prod_d;
      cnt_q    <= cnt_d;
      man_q    <= man_d;
      grd_q    <= grd_d;
      stk_q    <= stk_d;
      result_q <= result_d;
      flags_q  <= flags_d;
    end
  end
endmodule

// File: doc/fp_mul_seq.md
FP_MUL_SEQ -- requirements
Module: fp_mul_seq

Interface
REQ-001 SHALL have parameter EXP_W, default 8, exponent field width.
REQ-002 SHALL have parameter MAN_W, default 23, stored mantissa field width; operand width W = 1+EXP_W+MAN_W; BIAS = 2^(EXP_W-1)-1.
REQ-003 SHALL use one clock and a synchronous, active-high reset, as ports clk and rst.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 in_valid  input  1  operands and rm valid.
REQ-007 in_ready  output  1  block can accept a new operation.
REQ-008 in_numA, in_numB  input  W  IEEE-754-format operands.
REQ-009 rm  input  3  rounding mode: 0 RNE, 1 RTZ, 2 RDN, 3 RUP, 4 RMM.
REQ-010 out_valid  output  1  out_result and fflags valid.
REQ-011 out_ready  input  1  consumer accepts the result.
REQ-012 out_result  output  W  rounded product.
REQ-013 fflags  output  5  {NV,DZ,OF,UF,NX}; DZ is always 0.

Function
REQ-014 SHALL use FSM states IDLE, MUL, NORM, RND, DONE; in_ready = (state==IDLE); out_valid = (state==DONE).
REQ-015 Acceptance SHALL be in_valid&in_ready at a rising edge; operands and rm SHALL be registered on that edge and ignored afterwards.
REQ-016 On acceptance of finite normal operands: IDLE->MUL; the multiply SHALL be iterative shift-add, one multiplier bit per cycle, MAN_W+1 cycles, into a 2*(MAN_W+1)-bit product.
REQ-017 MUL->NORM after MAN_W+1 cycles, NORM->RND, RND->DONE, one cycle each; out_valid SHALL rise after edge E+MAN_W+3 for acceptance edge E (E+26 at defaults).
REQ-018 Special operands (any zero, inf, NaN, or subnormal) SHALL go IDLE->DONE on the acceptance edge with the special result.
REQ-019 DONE SHALL hold out_result and fflags stable until out_valid&out_ready; that edge SHALL go DONE->IDLE; a new operation is not accepted in the same cycle.
REQ-020 Sign = signA XOR signB for all non-NaN results.
REQ-021 Exponent SHALL be computed as expA+expB-BIAS in signed EXP_W+2 bits, +1 when product MSB is set; the mantissa SHALL be normalised to MAN_W+1 bits with guard bit and sticky OR of all lower bits.
REQ-022 Rounding per rm; RMM rounds ties away from zero; mantissa carry-out on rounding SHALL increment the exponent; NX SHALL be set when guard|sticky.
REQ-023 Rounded exponent >= 2^EXP_W-1: OF|NX; result inf for RNE/RMM, RUP on positive, RDN on negative; otherwise max finite (exp all-ones-minus-1, mantissa all ones).
REQ-024 Rounded exponent <= 0: result signed zero, UF|NX (flush, no subnormal output).
REQ-025 Subnormal inputs SHALL be treated as signed zero.
REQ-026 Any NaN input, inf*0, or rm in 5..7: canonical NaN (sign 0, exponent all ones, mantissa MSB 1, rest 0); NV SHALL be set for sNaN input, inf*0, or rm 5..7.
REQ-027 inf*nonzero-finite or inf*inf SHALL give signed inf, flags 0; zero*finite SHALL give signed zero, flags 0.

Reset
REQ-028 rst high at an edge SHALL force IDLE, in_ready=1, out_valid=0, out_result=0, fflags=0, counter and datapath registers cleared, regardless of state, including mid-MUL or DONE.
REQ-029 rst SHALL take priority over acceptance and output handshake in the same cycle.

Verification
REQ-030 0x3FC00000*0x40000000, RNE -> 0x40400000, fflags 0, out_valid after edge E+26.
REQ-031 0x3F800001*0x3F800001, RNE -> 0x3F800002, NX; same with RUP -> 0x3F800003, NX.
REQ-032 0x7F7FFFFF*0x40000000: RNE -> 0x7F800000, OF|NX; RTZ -> 0x7F7FFFFF, OF|NX.
REQ-033 0x7F800000*0x00000000 -> 0x7FC00000, NV, out_valid after edge E; 0x7FA00000*0x3F800000 -> 0x7FC00000, NV.
REQ-034 Hold out_ready low 5 cycles in DONE -> out_result/fflags unchanged, in_ready 0; then out_ready 1 -> IDLE, in_ready 1 next cycle.
REQ-035 Assert rst during MUL cycle 10 -> next cycle IDLE, out_valid 0, in_ready 1; no stale result ever presented.
